// File: rtl/poly_coeff_loader.sv
// Serial-to-parallel operand loader for poly_add: collects (a_k, b_k) beats into
// two packed polynomials and holds them under an out_valid/out_ready handshake.
module poly_coeff_loader #(
    parameter int DEG = 4,
    parameter int N   = 4,
    parameter int CW  = $clog2(DEG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DEG*N-1:0] a,
    output logic [DEG*N-1:0] b,
    output logic [CW:0]      count
);

    typedef enum logic {FILL, FULL} state_t;

    state_t           state_q, state_d;
    logic [DEG*N-1:0] a_q, a_d;
    logic [DEG*N-1:0] b_q, b_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [CW:0]      count_q, count_d;
    logic             beat;

    // Ready stays combinational so a draining FULL buffer can take the next beat at once.
    assign in_ready = (state_q == FILL) | ((state_q == FULL) & out_ready);
    assign beat     = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        count_d = count_q;
        if (clear) begin
            state_d = FILL;
            a_d     = '0;
            b_d     = '0;
            idx_d   = '0;
            count_d = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (beat) begin
                        for (int k = 0; k < DEG; k++) begin
                            if (idx_q == CW'(k)) begin
                                a_d[k*N +: N] = in_a;
                                b_d[k*N +: N] = in_b;
                            end
                        end
                        count_d = count_q + 1'b1;
                        if (in_last || idx_q == CW'(DEG - 1)) begin
                            state_d = FULL;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        // Handoff: consumer takes the old pair, buffer restarts at coefficient 0.
                        state_d = FILL;
                        a_d     = '0;
                        b_d     = '0;
                        idx_d   = '0;
                        count_d = '0;
                        if (in_valid) begin
                            a_d[N-1:0] = in_a;
                            b_d[N-1:0] = in_b;
                            idx_d      = CW'(1);
                            count_d    = (CW+1)'(1);
                            if (in_last) begin
                                state_d = FULL;
                            end
                        end
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign a         = a_q;
    assign b         = b_q;
    assign count     = count_q;

endmodule

// File: tb/tb_poly_coeff_loader.sv
// Self-checking bench for poly_coeff_loader: directed scenarios plus a random
// stream compared against an array-based model of the loading rules.
module tb_poly_coeff_loader;

    localparam int DEG = 4;
    localparam int N   = 4;
    localparam int CW  = 2;

    logic             clk = 1'b0;
    logic             rst, clear, in_valid, in_ready, in_last, out_valid, out_ready;
    logic [N-1:0]     in_a, in_b;
    logic [DEG*N-1:0] a, b;
    logic [CW:0]      count;

    int checks = 0;
    int errors = 0;

    // Model: coefficient arrays, number loaded, and whether the pair is complete.
    logic [N-1:0] m_a [DEG];
    logic [N-1:0] m_b [DEG];
    int           m_n;
    bit           m_full;

    poly_coeff_loader #(.DEG(DEG), .N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not finish, got stuck, required completion");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [DEG*N-1:0] pack_a();
        logic [DEG*N-1:0] v = '0;
        for (int k = 0; k < DEG; k++) v[k*N +: N] = m_a[k];
        return v;
    endfunction

    function automatic logic [DEG*N-1:0] pack_b();
        logic [DEG*N-1:0] v = '0;
        for (int k = 0; k < DEG; k++) v[k*N +: N] = m_b[k];
        return v;
    endfunction

    function automatic bit m_ready();
        return !m_full || out_ready;
    endfunction

    task automatic model_empty();
        for (int k = 0; k < DEG; k++) begin
            m_a[k] = '0;
            m_b[k] = '0;
        end
        m_n    = 0;
        m_full = 0;
    endtask

    task automatic model_update();
        if (rst || clear) begin
            model_empty();
        end else if (!m_full) begin
            if (in_valid) begin
                m_a[m_n] = in_a;
                m_b[m_n] = in_b;
                m_n++;
                if (in_last || m_n == DEG) m_full = 1;
            end
        end else if (out_ready) begin
            model_empty();
            if (in_valid) begin
                m_a[0] = in_a;
                m_b[0] = in_b;
                m_n    = 1;
                if (in_last) m_full = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] da, input logic [N-1:0] db,
                         input logic last, input logic ordy);
        in_valid  = v;
        in_a      = da;
        in_b      = db;
        in_last   = last;
        out_ready = ordy;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 4'h7, 4'h3, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        checks++;
        if (out_valid !== 1'b0 || a !== '0 || b !== '0 || count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: out_valid=%b a=%h b=%h count=%0d, required 0/0/0/0", out_valid, a, b, count);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_full_load();
        logic [N-1:0]     beats [4] = '{4'hF, 4'h5, 4'hA, 4'hA};
        logic [DEG*N-1:0] s;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, beats[i], beats[i], i == 3, 1'b1);
            tick();
            checks++;
            if (out_valid !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL full_load_valid beat %0d: got %b, required %b", i, out_valid, i == 3);
            end
        end
        checks++;
        if (a !== 16'hAA5F || b !== 16'hAA5F || a !== pack_a()) begin
            errors++;
            $display("[TB] FAIL full_load_data: a=%h b=%h, required aa5f/aa5f", a, b);
        end
        for (int k = 0; k < DEG; k++) s[k*N +: N] = a[k*N +: N] + b[k*N +: N];
        checks++;
        if (s !== 16'h44AE) begin
            errors++;
            $display("[TB] FAIL full_load_sum: got %h, required 44ae", s);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== '0) begin
            errors++;
            $display("[TB] FAIL full_load_pulse: out_valid=%b count=%0d, required 0/0", out_valid, count);
        end
    endtask

    task automatic test_short();
        drive(1'b1, 4'h3, 4'h1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'h7, 4'h2, 1'b1, 1'b0);
        tick();
        checks++;
        if (a !== 16'h0073 || b !== 16'h0021 || count !== 3'd2 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL short_poly: a=%h b=%h count=%0d valid=%b, required 0073/0021/2/1", a, b, count, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [DEG*N-1:0] ha, hb;
        logic [CW:0]      hc;
        ha = a;
        hb = b;
        hc = count;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_ready cycle %0d: got %b, required 0", i, in_ready);
            end
            tick();
            checks++;
            if (a !== ha || b !== hb || count !== hc || out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle %0d: a=%h b=%h count=%0d, required %h/%h/%0d", i, a, b, count, ha, hb, hc);
            end
        end
        drive(1'b1, 4'h9, 4'h9, 1'b0, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release_ready: got %b, required 1", in_ready);
        end
        tick();
        checks++;
        if (a !== 16'h0009 || b !== 16'h0009 || count !== 3'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_handoff: a=%h b=%h count=%0d valid=%b, required 0009/0009/1/0", a, b, count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b1);
            tick();
            checks++;
            if (out_valid !== (i == 3 || i == 7)) begin
                errors++;
                $display("[TB] FAIL b2b_valid cycle %0d: got %b, required %b", i + 1, out_valid, (i == 3 || i == 7));
            end
            checks++;
            if (a !== pack_a() || b !== pack_b() || count !== (CW+1)'(m_n)) begin
                errors++;
                $display("[TB] FAIL b2b_data cycle %0d: a=%h b=%h count=%0d, required %h/%h/%0d", i + 1, a, b, count, pack_a(), pack_b(), m_n);
            end
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
            tick();
        end
        clear = 1'b1;
        drive(1'b1, 4'hC, 4'hD, 1'b0, 1'b0);
        tick();
        clear = 1'b0;
        checks++;
        if (a !== '0 || b !== '0 || count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_state: a=%h b=%h count=%0d valid=%b, required 0/0/0/0", a, b, count, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (a !== pack_a() || b !== pack_b() || out_valid !== 1'b1 || count !== 3'd4) begin
            errors++;
            $display("[TB] FAIL clear_refill: a=%h b=%h valid=%b count=%0d, required %h/%h/1/4", a, b, out_valid, count, pack_a(), pack_b());
        end
    endtask

    task automatic test_reset_full();
        for (int pass = 0; pass < 2; pass++) begin
            do_clear();
            for (int i = 0; i < 4; i++) begin
                drive(1'b1, 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 1'b0, 1'b0);
                tick();
            end
            rst   = 1'b1;
            clear = (pass == 1);
            drive(1'b1, 4'h5, 4'h6, 1'b0, 1'b0);
            tick();
            rst   = 1'b0;
            clear = 1'b0;
            drive(1'b0, '0, '0, 1'b0, 1'b0);
            #1;
            checks++;
            if (out_valid !== 1'b0 || a !== '0 || b !== '0 || count !== '0 || in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rst_in_full pass %0d: valid=%b a=%h b=%h count=%0d ready=%b, required 0/0/0/0/1", pass, out_valid, a, b, count, in_ready);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 59) == 0);
            clear = ($urandom_range(0, 24) == 0);
            drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (in_ready !== m_ready()) begin
                errors++;
                $display("[TB] FAIL rand_ready cycle %0d: got %b, required %b", i, in_ready, m_ready());
            end
            tick();
            checks++;
            if (out_valid !== m_full || a !== pack_a() || b !== pack_b() || count !== (CW+1)'(m_n)) begin
                errors++;
                $display("[TB] FAIL rand_state cycle %0d: valid=%b a=%h b=%h count=%0d, required %b/%h/%h/%0d",
                         i, out_valid, a, b, count, m_full, pack_a(), pack_b(), m_n);
            end
        end
        rst   = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        rst   = 1'b0;
        clear = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        model_empty();
        #1;
        test_reset();
        test_full_load();
        test_short();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_reset_full();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
